fc5_seq: RTL and testbench
==========================

# fc5_seq

Sequencer for the layer-5 fully connected stage: a 16-input by 16-output dot product whose weights sit in sixteen 16-entry signed 8-bit weight banks. On `start` it clears the sixteen lane accumulators, then broadcasts one read address per cycle to all weight banks and to the input activation buffer. It enables accumulation aligned to the memory read latency, drains the sixteen results through a valid/ready port, and pulses `finish`.

## Interface
- `N_IN`, default 16: input activations per pass. Fixed to the 4-bit bank depth.
- `N_LANE`, default 16: output lanes, one per weight bank.
- `RD_LAT`, default 1: weight/activation read latency in cycles; legal range 1..3.
- `clk`  in  1: rising-edge clock.
- `xrst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle request to run a pass; accepted only in IDLE.
- `w_raddr`  out  4: read address broadcast to all 16 weight banks.
- `x_raddr`  out  4: input activation buffer read address; always equal to `w_raddr`.
- `acc_clr`  out  1: clear all lane accumulators.
- `acc_en`  out  1: accumulate the current bank data times activation in every lane.
- `out_valid`  out  1: lane result selected by `out_sel` is presented.
- `out_ready`  in  1: downstream accepts the presented result.
- `out_sel`  out  4: index of the lane being drained.
- `busy`  out  1: high in every state except IDLE.
- `finish`  out  1: one-cycle pulse when the pass completes.

## Operation
- FSM states: IDLE, CLR, FEED, FLUSH, OUT, FIN.
- IDLE: on `start`, go to CLR. Otherwise stay. All outputs are 0.
- CLR, 1 cycle: `acc_clr`=1. Address counter resets to 0. Go to FEED.
- FEED, N_IN cycles: `w_raddr`=`x_raddr`=counter, running 0..15. The counter increments each cycle. After address 15, go to FLUSH.
- Issue tracking: a RD_LAT-deep shift register of "issued" bits. `acc_en` is the output of this shift register, so `acc_en` is high for exactly N_IN cycles.
- FLUSH, RD_LAT cycles: no new addresses are issued, and `w_raddr` holds at 0. Leave when the shift register is empty, then go to OUT.
- OUT: `out_valid`=1 and `out_sel` = drain counter, starting at 0. On `out_valid & out_ready`, increment the counter. The handshake with `out_sel`=15 moves the FSM to FIN. While `out_ready` is low, `out_sel` holds.
- FIN, 1 cycle: `finish`=1. Go to IDLE.
- `start` is ignored outside IDLE. No queuing.
- `start` together with `xrst` resolves as reset.
- `xrst` at any cycle, including mid-FEED or mid-OUT: next state is IDLE. Counters, the shift register and all outputs are 0. No `finish` pulse is produced for an aborted pass.
- Counters are 4-bit and wrap naturally. Terminal detection uses ==15, not overflow.
- Arithmetic (8x8 signed products, accumulator width) lives in the lane datapath. This block carries no data.

## Timing
- Reset value of every output: 0.
- With `start` sampled at cycle 0:
  - CLR at cycle 1.
  - FEED cycles 2..17, addresses 0..15.
  - `acc_en` high on cycles 2+RD_LAT..17+RD_LAT.
  - FLUSH cycles 18..17+RD_LAT.
  - First `out_valid` at cycle 18+RD_LAT.
- With `out_ready` held high, the drain takes 16 cycles and `finish` falls at cycle 34+RD_LAT. For RD_LAT=1 that is cycle 35.
- Each `out_ready` low cycle adds one cycle of latency.
- `busy` rises the cycle after `start` and falls the cycle after `finish`.
- All outputs are registered. There are no combinational paths from inputs to outputs, except that `out_sel` advance depends on the registered handshake only.

## Structure
- Shared package `fc5_pkg` holds:
  - the state enum `fc5_state_t`;
  - constants `FC5_N_IN`, `FC5_N_LANE`, `FC5_ADDR_W`=4;
  - `FC5_RD_LAT_MAX`=3.
- One natural sub-module: `fc5_issue_pipe`, the RD_LAT shift register producing `acc_en` and an empty flag.
- The FSM and both counters stay in `fc5_seq`.

## Test plan
- Reset then `start` with RD_LAT=1 and `out_ready`=1:
  - `acc_clr` at cycle 1;
  - `w_raddr` 0..15 on cycles 2..17;
  - `acc_en` on cycles 3..18;
  - `out_sel` 0..15 on cycles 19..34;
  - `finish` at 35.
- RD_LAT=3: `acc_en` on cycles 5..20, first `out_valid` at 21, `finish` at 37.
- Backpressure: `out_ready` low on cycles 20..22.
  - `out_sel` holds at 1 for those cycles.
  - `finish` is delayed by 3 cycles to cycle 38.
- `start` pulsed at cycles 5 and 25 during a pass: ignored, and the timeline is unchanged.
- `xrst` asserted at cycle 10 (mid-FEED): all outputs 0 from cycle 11, no `finish`. A fresh `start` at cycle 12 gives `finish` 35 cycles later.
- Back-to-back passes: `start` on the cycle after `finish` is accepted and produces an identical timeline.

Source files
------------

// File: rtl/fc5_pkg.sv
// Shared types and constants for the layer-5 fully connected sequencer.
// Imported by the sequencer and its issue pipeline.
package fc5_pkg;

    localparam int unsigned FC5_N_IN       = 16;
    localparam int unsigned FC5_N_LANE     = 16;
    localparam int unsigned FC5_ADDR_W     = 4;
    localparam int unsigned FC5_RD_LAT_MAX = 3;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFeed,
        StFlush,
        StOut,
        StFin
    } fc5_state_t;

endpackage

// File: rtl/fc5_issue_pipe.sv
// Read-latency delay line of "address issued" bits; its tail is the lane accumulate enable.
// o_empty reports that no issued bit remains once the current output bit has retired.
module fc5_issue_pipe
    import fc5_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_xrst,
    input  logic i_issue,
    output logic o_acc_en,
    output logic o_empty
);

    logic [RD_LAT-1:0] r_sr;
    logic [RD_LAT-1:0] w_sr_nxt;

    if (RD_LAT == 0 || RD_LAT > FC5_RD_LAT_MAX) begin : g_lat_check
        $error("fc5_issue_pipe: RD_LAT must be in 1..%0d", FC5_RD_LAT_MAX);
    end

    if (RD_LAT == 1) begin : g_single
        assign w_sr_nxt = i_issue;
    end else begin : g_multi
        assign w_sr_nxt = {r_sr[RD_LAT-2:0], i_issue};
    end

    always_ff @(posedge i_clk) begin
        if (i_xrst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_nxt;
        end
    end

    assign o_acc_en = r_sr[RD_LAT-1];
    // Empty once the bits still in flight after this edge are all zero.
    assign o_empty  = ~|w_sr_nxt;

endmodule

// File: rtl/fc5_seq.sv
// Layer-5 FC sequencer: clears lane accumulators, streams 16 shared read addresses,
// aligns accumulate enables to the read latency, then drains 16 lane results.
module fc5_seq
    import fc5_pkg::*;
#(
    parameter int unsigned N_IN   = FC5_N_IN,
    parameter int unsigned N_LANE = FC5_N_LANE,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_xrst,
    input  logic                  i_start,
    output logic [FC5_ADDR_W-1:0] o_w_raddr,
    output logic [FC5_ADDR_W-1:0] o_x_raddr,
    output logic                  o_acc_clr,
    output logic                  o_acc_en,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [FC5_ADDR_W-1:0] o_out_sel,
    output logic                  o_busy,
    output logic                  o_finish
);

    localparam logic [FC5_ADDR_W-1:0] LastAddr = FC5_ADDR_W'(N_IN - 1);
    localparam logic [FC5_ADDR_W-1:0] LastLane = FC5_ADDR_W'(N_LANE - 1);

    fc5_state_t            r_state;
    fc5_state_t            w_state_nxt;
    logic [FC5_ADDR_W-1:0] r_addr;
    logic [FC5_ADDR_W-1:0] w_addr_nxt;
    logic [FC5_ADDR_W-1:0] r_sel;
    logic [FC5_ADDR_W-1:0] w_sel_nxt;

    logic [FC5_ADDR_W-1:0] r_raddr;
    logic                  r_acc_clr;
    logic                  r_out_valid;
    logic [FC5_ADDR_W-1:0] r_out_sel;
    logic                  r_busy;
    logic                  r_finish;

    logic                  w_issue;
    logic                  w_pipe_empty;
    logic                  w_handshake;

    assign w_issue     = (r_state == StFeed);
    assign w_handshake = r_out_valid & i_out_ready;

    fc5_issue_pipe #(
        .RD_LAT (RD_LAT)
    ) u_issue_pipe (
        .i_clk    (i_clk),
        .i_xrst   (i_xrst),
        .i_issue  (w_issue),
        .o_acc_en (o_acc_en),
        .o_empty  (w_pipe_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_sel_nxt   = r_sel;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = StClr;
                end
            end
            StClr: begin
                w_addr_nxt  = '0;
                w_sel_nxt   = '0;
                w_state_nxt = StFeed;
            end
            StFeed: begin
                // The wrap after the last address leaves the counter at 0 for FLUSH.
                w_addr_nxt = r_addr + FC5_ADDR_W'(1);
                if (r_addr == LastAddr) begin
                    w_state_nxt = StFlush;
                end
            end
            StFlush: begin
                w_sel_nxt = '0;
                if (w_pipe_empty) begin
                    w_state_nxt = StOut;
                end
            end
            StOut: begin
                if (w_handshake) begin
                    w_sel_nxt = r_sel + FC5_ADDR_W'(1);
                    if (r_sel == LastLane) begin
                        w_state_nxt = StFin;
                    end
                end
            end
            StFin: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Outputs are decoded from next state so each one is a flop.
    always_ff @(posedge i_clk) begin
        if (i_xrst) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_sel       <= '0;
            r_raddr     <= '0;
            r_acc_clr   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_busy      <= 1'b0;
            r_finish    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_sel       <= w_sel_nxt;
            r_raddr     <= (w_state_nxt == StFeed) ? w_addr_nxt : '0;
            r_acc_clr   <= (w_state_nxt == StClr);
            r_out_valid <= (w_state_nxt == StOut);
            r_out_sel   <= (w_state_nxt == StOut) ? w_sel_nxt : '0;
            r_busy      <= (w_state_nxt != StIdle);
            r_finish    <= (w_state_nxt == StFin);
        end
    end

    assign o_w_raddr   = r_raddr;
    assign o_x_raddr   = r_raddr;
    assign o_acc_clr   = r_acc_clr;
    assign o_out_valid = r_out_valid;
    assign o_out_sel   = r_out_sel;
    assign o_busy      = r_busy;
    assign o_finish    = r_finish;

endmodule

// File: tb/tb_fc5_seq.sv
// Directed bench for fc5_seq: RD_LAT=1 and RD_LAT=3 instances checked cycle by cycle
// against a timeline model, plus hand-computed finish cycles per scenario.
module tb_fc5_seq;

    logic       clk;
    logic       i_xrst;
    logic       i_start [2];
    logic       i_out_ready;
    logic [3:0] o_w_raddr [2];
    logic [3:0] o_x_raddr [2];
    logic       o_acc_clr [2];
    logic       o_acc_en [2];
    logic       o_out_valid [2];
    logic [3:0] o_out_sel [2];
    logic       o_busy [2];
    logic       o_finish [2];

    int n_tests = 0;
    int n_fail  = 0;
    int fin1;
    int fin3;

    fc5_seq #(.RD_LAT(1)) u_dut1 (
        .i_clk       (clk),
        .i_xrst      (i_xrst),
        .i_start     (i_start[0]),
        .o_w_raddr   (o_w_raddr[0]),
        .o_x_raddr   (o_x_raddr[0]),
        .o_acc_clr   (o_acc_clr[0]),
        .o_acc_en    (o_acc_en[0]),
        .o_out_valid (o_out_valid[0]),
        .i_out_ready (i_out_ready),
        .o_out_sel   (o_out_sel[0]),
        .o_busy      (o_busy[0]),
        .o_finish    (o_finish[0])
    );

    fc5_seq #(.RD_LAT(3)) u_dut3 (
        .i_clk       (clk),
        .i_xrst      (i_xrst),
        .i_start     (i_start[1]),
        .o_w_raddr   (o_w_raddr[1]),
        .o_x_raddr   (o_x_raddr[1]),
        .o_acc_clr   (o_acc_clr[1]),
        .o_acc_en    (o_acc_en[1]),
        .o_out_valid (o_out_valid[1]),
        .i_out_ready (i_out_ready),
        .o_out_sel   (o_out_sel[1]),
        .o_busy      (o_busy[1]),
        .o_finish    (o_finish[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input int k, input logic [31:0] e_addr,
                               input bit e_clr, input bit e_en, input bit e_val,
                               input logic [31:0] e_sel, input bit e_busy, input bit e_fin);
        chk({tag, " w_raddr"}, 32'(o_w_raddr[k]), e_addr);
        chk({tag, " x_raddr"}, 32'(o_x_raddr[k]), e_addr);
        chk({tag, " acc_clr"}, 32'(o_acc_clr[k]), 32'(e_clr));
        chk({tag, " acc_en"}, 32'(o_acc_en[k]), 32'(e_en));
        chk({tag, " out_valid"}, 32'(o_out_valid[k]), 32'(e_val));
        chk({tag, " out_sel"}, 32'(o_out_sel[k]), e_sel);
        chk({tag, " busy"}, 32'(o_busy[k]), 32'(e_busy));
        chk({tag, " finish"}, 32'(o_finish[k]), 32'(e_fin));
    endtask

    // One pass window of ncyc cycles; cycle 0 is the start cycle. Negative g1/g2/rst_at
    // disable the extra start pulses and the mid-pass reset.
    task automatic run_pass(input string name, input int ncyc, input bit en1, input bit en3,
                            input int rlo, input int rhi, input int g1, input int g2,
                            input int rst_at, output int f1, output int f3);
        int lat [2];
        bit en [2];
        int m [2];
        int fmod [2];
        int fobs [2];
        lat[0] = 1;
        lat[1] = 3;
        en[0]  = en1;
        en[1]  = en3;
        for (int k = 0; k < 2; k++) begin
            m[k]    = 0;
            fmod[k] = 1000;
            fobs[k] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            bit rdy;
            rdy         = !(c >= rlo && c <= rhi);
            i_out_ready = rdy;
            i_xrst      = (c == rst_at);
            for (int k = 0; k < 2; k++) begin
                i_start[k] = en[k] && (c == 0 || c == g1 || c == g2);
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit          live;
                bit          e_val;
                logic [31:0] e_addr;
                live   = en[k] && !(rst_at >= 0 && c > rst_at);
                e_addr = (live && c >= 2 && c <= 17) ? 32'(c - 2) : 32'd0;
                e_val  = live && c >= 18 + lat[k] && c < fmod[k];
                chk_outputs($sformatf("%s L%0d c%0d", name, lat[k], c), k, e_addr,
                            live && c == 1,
                            live && c >= 2 + lat[k] && c <= 17 + lat[k],
                            e_val, e_val ? 32'(m[k]) : 32'd0,
                            live && c >= 1 && c <= fmod[k],
                            live && c == fmod[k]);
                if (o_finish[k] === 1'b1) fobs[k] = c;
                if (e_val && rdy) begin
                    if (m[k] == 15) fmod[k] = c + 1;
                    m[k]++;
                end
            end
            @(posedge clk);
            #1;
        end
        i_start[0]  = 1'b0;
        i_start[1]  = 1'b0;
        i_xrst      = 1'b0;
        i_out_ready = 1'b1;
        f1 = fobs[0];
        f3 = fobs[1];
    endtask

    initial begin
        i_xrst      = 1'b1;
        i_start[0]  = 1'b1;
        i_start[1]  = 1'b1;
        i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        // Start held with reset must resolve as reset.
        for (int k = 0; k < 2; k++) begin
            chk_outputs($sformatf("reset L%0d", k == 0 ? 1 : 3), k, 32'd0,
                        1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        i_xrst     = 1'b0;
        i_start[0] = 1'b0;
        i_start[1] = 1'b0;
        @(posedge clk);
        #1;

        run_pass("basic", 40, 1'b1, 1'b1, -1, -1, -1, -1, -1, fin1, fin3);
        chk("basic finish L1", 32'(fin1), 32'd35);
        chk("basic finish L3", 32'(fin3), 32'd37);

        run_pass("bp", 42, 1'b1, 1'b1, 20, 22, -1, -1, -1, fin1, fin3);
        chk("bp finish L1", 32'(fin1), 32'd38);
        chk("bp finish L3", 32'(fin3), 32'd39);

        run_pass("ign", 40, 1'b1, 1'b1, -1, -1, 5, 25, -1, fin1, fin3);
        chk("ign finish L1", 32'(fin1), 32'd35);
        chk("ign finish L3", 32'(fin3), 32'd37);

        run_pass("abort", 12, 1'b1, 1'b1, -1, -1, -1, -1, 10, fin1, fin3);
        chk("abort finish L1", 32'(fin1), 32'hFFFF_FFFF);
        chk("abort finish L3", 32'(fin3), 32'hFFFF_FFFF);

        run_pass("fresh", 36, 1'b1, 1'b0, -1, -1, -1, -1, -1, fin1, fin3);
        chk("fresh finish L1", 32'(fin1), 32'd35);

        run_pass("b2b", 38, 1'b1, 1'b0, -1, -1, -1, -1, -1, fin1, fin3);
        chk("b2b finish L1", 32'(fin1), 32'd35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
